// File: rtl/med_pkg.sv
// Shared types and constants for the rank-order filter.
// MED_SIGNED_EN selects two's-complement samples and the matching sentinel.
package med_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int TAILLE_DEF = 8;
    localparam int NMBR_DEF   = 9;

`ifdef MED_SIGNED_EN
    localparam logic SIGNED_SAMPLES = 1'b1;
`else
    localparam logic SIGNED_SAMPLES = 1'b0;
`endif

    // Sentinel must never exceed a real sample: zero unsigned, most negative signed.
    function automatic logic [255:0] sent_val(int w);
        return {255'd0, SIGNED_SAMPLES} << (w - 1);
    endfunction

endpackage

// File: rtl/med_rank_filter_if.sv
// Sample-in / result-out handshake bundle of the rank-order filter.
interface med_rank_filter_if #(
    parameter int TAILLE = 8,
    parameter int NMBR   = 9
);
    localparam int RW = $clog2(NMBR);

    logic              DSI;
    logic [TAILLE-1:0] DI;
    logic [RW-1:0]     RANK;
    logic              DRDY;
    logic [TAILLE-1:0] DO;
    logic              DSO;

    modport master (output DSI, DI, RANK, input DRDY, DO, DSO);
    modport slave  (input DSI, DI, RANK, output DRDY, DO, DSO);
endinterface

// File: rtl/med_cmp_exch.sv
// Combinational compare-exchange cell; signed compare when MED_SIGNED_EN is defined.
module med_cmp_exch #(
    parameter int TAILLE = 8
) (
    input  logic [TAILLE-1:0] A,
    input  logic [TAILLE-1:0] B,
    output logic [TAILLE-1:0] MAX,
    output logic [TAILLE-1:0] MIN
);
    logic a_gt;

`ifdef MED_SIGNED_EN
    assign a_gt = $signed(A) > $signed(B);
`else
    assign a_gt = A > B;
`endif

    assign MAX = a_gt ? A : B;
    assign MIN = a_gt ? B : A;
endmodule

// File: rtl/med_rank_filter.sv
// Rank-order filter: loads NMBR samples, then extracts the rk-th smallest by repeated
// max-extraction passes over a compare-exchange ring. Sample signedness via MED_SIGNED_EN.
module med_rank_filter
    import med_pkg::*;
#(
    parameter int TAILLE = TAILLE_DEF,
    parameter int NMBR   = NMBR_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    med_rank_filter_if.slave    bus
);
    localparam int RW = $clog2(NMBR);
    localparam int CW = $clog2(NMBR);
    localparam int PW = $clog2(NMBR + 1);
    localparam logic [255:0]      SENT_W = sent_val(TAILLE);
    localparam logic [TAILLE-1:0] SENT   = SENT_W[TAILLE-1:0];

    state_e            state_q, state_d;
    logic [TAILLE-1:0] r_q [NMBR];
    logic [TAILLE-1:0] r_d [NMBR];
    logic [PW-1:0]     pass_q, pass_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [CW-1:0]     ld_q, ld_d;
    logic [RW-1:0]     rk_q, rk_d;
    logic [TAILLE-1:0] do_q, do_d;

    logic [TAILLE-1:0] cx_max, cx_min;
    logic [RW-1:0]     rank_clamped;

    med_cmp_exch #(.TAILLE(TAILLE)) u_cmp (
        .A   (r_q[NMBR-2]),
        .B   (r_q[NMBR-1]),
        .MAX (cx_max),
        .MIN (cx_min)
    );

    assign rank_clamped = (bus.RANK > RW'(NMBR - 1)) ? RW'(NMBR - 1) : bus.RANK;

    assign bus.DRDY = (state_q == ST_LOAD) && !RST;
    assign bus.DSO  = (state_q == ST_DONE) && !RST;
    assign bus.DO   = do_q;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        pass_d  = pass_q;
        cyc_d   = cyc_q;
        ld_d    = ld_q;
        rk_d    = rk_q;
        do_d    = do_q;
        case (state_q)
            ST_LOAD: begin
                if (bus.DSI) begin
                    for (int i = 1; i < NMBR; i++) r_d[i] = r_q[i-1];
                    r_d[0] = bus.DI;
                    if (ld_q == '0) rk_d = rank_clamped;
                    if (ld_q == CW'(NMBR - 1)) begin
                        ld_d    = '0;
                        cyc_d   = '0;
                        pass_d  = PW'(NMBR) - PW'(rk_q);
                        state_d = ST_SORT;
                    end else begin
                        ld_d = ld_q + CW'(1);
                    end
                end
            end
            ST_SORT: begin
                if (cyc_q != CW'(NMBR - 1)) begin
                    // Bubble the larger of the pair into the accumulator, recirculate the smaller.
                    for (int i = 1; i < NMBR - 1; i++) r_d[i] = r_q[i-1];
                    r_d[0]      = cx_min;
                    r_d[NMBR-1] = cx_max;
                    cyc_d       = cyc_q + CW'(1);
                end else if (pass_q == PW'(1)) begin
                    do_d    = r_q[NMBR-1];
                    cyc_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    for (int i = 1; i < NMBR; i++) r_d[i] = r_q[i-1];
                    r_d[0] = SENT;
                    pass_d = pass_q - PW'(1);
                    cyc_d  = '0;
                end
            end
            ST_DONE: state_d = ST_LOAD;
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_LOAD;
            for (int i = 0; i < NMBR; i++) r_q[i] <= '0;
            pass_q  <= '0;
            cyc_q   <= '0;
            ld_q    <= '0;
            rk_q    <= '0;
            do_q    <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            pass_q  <= pass_d;
            cyc_q   <= cyc_d;
            ld_q    <= ld_d;
            rk_q    <= rk_d;
            do_q    <= do_d;
        end
    end
endmodule

// File: tb/tb_med_rank_filter.sv
// Bench for med_rank_filter (NMBR=9, TAILLE=8); extra signed cases when MED_SIGNED_EN is defined.
module tb_med_rank_filter;
    localparam int N = 9;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    med_rank_filter_if #(.TAILLE(8), .NMBR(N)) bus ();
    med_rank_filter #(.TAILLE(8), .NMBR(N)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [8:0][7:0] s;
        int              rank;
        logic [7:0]      exp_do;
        int              exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Feed order is s[8] first; RANK is scrambled after the first sample to prove it is latched once.
    task automatic feed_window(input logic [8:0][7:0] s, input int rank);
        for (int i = N - 1; i >= 0; i--) begin
            int guard = 0;
            bus.DSI = 1'b1;
            bus.DI  = s[i];
            bus.RANK = (i == N - 1) ? 4'(rank) : 4'(rank + 5);
            while (!bus.DRDY && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) check("drdy_timeout", 0, 1);
            tick();
        end
        bus.DSI = 1'b0;
    endtask

    task automatic wait_result(input bit inject, output logic [7:0] dout, output int lat);
        lat = 0;
        if (inject) begin
            bus.DSI = 1'b1;
            bus.DI  = 8'hAA;
        end
        while (lat < 200) begin
            tick();
            lat++;
            if (bus.DSO) break;
        end
        bus.DSI = 1'b0;
        if (!bus.DSO) check("dso_timeout", 0, 1);
        dout = bus.DO;
    endtask

    function automatic logic [7:0] model(input logic [8:0][7:0] s, input int rank);
        int q[$];
        int rk;
        rk = (rank > N - 1) ? N - 1 : rank;
        for (int i = 0; i < N; i++) begin
`ifdef MED_SIGNED_EN
            q.push_back(int'($signed(s[i])));
`else
            q.push_back(int'(s[i]));
`endif
        end
        q.sort();
        return 8'(q[rk]);
    endfunction

    initial begin
        logic [7:0] dout;
        int lat;
        logic [8:0][7:0] rs;
        int rr;

        vecs[0] = '{s: {8'd9,8'd1,8'd8,8'd2,8'd7,8'd3,8'd6,8'd4,8'd5}, rank: 4, exp_do: 8'd5, exp_lat: 45};
        vecs[1] = '{s: {8'd9,8'd1,8'd8,8'd2,8'd7,8'd3,8'd6,8'd4,8'd5}, rank: 0, exp_do: 8'd1, exp_lat: 81};
        vecs[2] = '{s: {8'd9,8'd1,8'd8,8'd2,8'd7,8'd3,8'd6,8'd4,8'd5}, rank: 8, exp_do: 8'd9, exp_lat: 9};
        vecs[3] = '{s: '0, rank: 4, exp_do: 8'h00, exp_lat: 45};
        vecs[4] = '{s: {8'h00,8'h00,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'hFF,8'hFF}, rank: 4, exp_do: 8'hFF, exp_lat: 45};
        vecs[5] = '{s: {8'd10,8'd20,8'd30,8'd40,8'd50,8'd60,8'd70,8'd80,8'd90}, rank: 4, exp_do: 8'd50, exp_lat: 45};
        vecs[6] = '{s: {8'd30,8'd90,8'd10,8'd50,8'd70,8'd20,8'd80,8'd40,8'd60}, rank: 12, exp_do: 8'd90, exp_lat: 9};

        bus.DSI = 1'b0;
        bus.DI = '0;
        bus.RANK = '0;
        tick();
        tick();
        check("drdy_in_reset", 32'(bus.DRDY), 0);
        RST = 1'b0;
        #1;
        check("reset_do", 32'(bus.DO), 0);
        check("reset_dso", 32'(bus.DSO), 0);
        check("reset_drdy", 32'(bus.DRDY), 1);

        for (int v = 0; v < 7; v++) begin
            feed_window(vecs[v].s, vecs[v].rank);
            wait_result(1'b0, dout, lat);
            check($sformatf("vec%0d_do", v), 32'(dout), 32'(vecs[v].exp_do));
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_drdy_done", v), 32'(bus.DRDY), 0);
            tick();
            check($sformatf("vec%0d_dso_pulse", v), 32'(bus.DSO), 0);
            check($sformatf("vec%0d_drdy_after", v), 32'(bus.DRDY), 1);
            check($sformatf("vec%0d_do_hold", v), 32'(bus.DO), 32'(vecs[v].exp_do));
        end

        // DSI strobes with 0xAA throughout SORT must be dropped.
        feed_window(vecs[0].s, 4);
        wait_result(1'b1, dout, lat);
        check("ignore_dsi_do", 32'(dout), 5);
        check("ignore_dsi_lat", 32'(lat), 45);
        tick();

        // Abort mid-SORT with DO holding a nonzero result.
        feed_window(vecs[0].s, 0);
        repeat (10) tick();
        check("abort_no_early_dso", 32'(bus.DSO), 0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        check("abort_do", 32'(bus.DO), 0);
        check("abort_dso", 32'(bus.DSO), 0);
        check("abort_drdy", 32'(bus.DRDY), 1);
        feed_window(vecs[5].s, 4);
        wait_result(1'b0, dout, lat);
        check("abort_fresh_do", 32'(dout), 50);
        check("abort_fresh_lat", 32'(lat), 45);
        tick();

`ifdef MED_SIGNED_EN
        feed_window({8'd2,8'hFC,8'd0,8'd4,8'hFE,8'd1,8'hFD,8'd3,8'hFF}, 4);
        wait_result(1'b0, dout, lat);
        check("signed_median", 32'(dout), 32'h00);
        tick();
        feed_window({8'd2,8'hFC,8'd0,8'd4,8'hFE,8'd1,8'hFD,8'd3,8'hFF}, 0);
        wait_result(1'b0, dout, lat);
        check("signed_min", 32'(dout), 32'hFC);
        check("signed_min_lat", 32'(lat), 81);
        tick();
`endif

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++)
                rs[i] = (t % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
            rr = $urandom_range(0, 15);
            feed_window(rs, rr);
            wait_result(1'b0, dout, lat);
            check($sformatf("rand%0d_do", t), 32'(dout), 32'(model(rs, rr)));
            check($sformatf("rand%0d_lat", t), 32'(lat), 32'((N - ((rr > N - 1) ? N - 1 : rr)) * N));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
